ao_bus_arbiter: RTL and testbench

Round-robin, burst-aware arbiter that shares one WIDTH-bit AND-OR merge path between two requesters and a priority override source. It sits in front of the aes128 round datapath input bus: requesters 0 and 1 are the plaintext loader and the key-schedule feeder, and the override carries test and debug words. Grants are registered, and the merge itself is pure AND-OR, so the shared path remains a gate-level AO tree after synthesis.

---
 rtl/ao_arb_pkg.sv | 21 ++
 rtl/ao_merge.sv | 29 ++
 rtl/ao_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_ao_bus_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ao_arb_pkg.sv
// Shared types and constants for the AND-OR bus arbiter.
//   arb_state_t   : arbiter ownership state (IDLE, OWN0, OWN1, OVR)
//   STATE_RST     : state after reset
//   PTR_RST       : round-robin pointer after reset (requester 0 first)
//   DEF_WIDTH     : default beat width
//   DEF_MAX_BURST : default maximum beats per grant
package ao_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        OVR  = 2'd3
    } arb_state_t;

    localparam arb_state_t STATE_RST     = IDLE;
    localparam logic       PTR_RST       = 1'b0;
    localparam int         DEF_WIDTH     = 8;
    localparam int         DEF_MAX_BURST = 16;

endpackage

// File: rtl/ao_merge.sv
// Three-term AND-OR merge of beat data and valid. Kept as its own module so
// the shared datapath stays a separable gate-level AO tree.
//   i_gnt0/i_gnt1/i_ovr_gnt : one-hot (or zero) grant selects
//   i_req0/i_req1/i_ovr_en  : per-source beat offered
//   i_data0/i_data1/i_ovr_data : per-source beat data
//   o_valid/o_data          : merged beat
module ao_merge #(
    parameter int WIDTH = 8
) (
    input  logic             i_gnt0,
    input  logic             i_gnt1,
    input  logic             i_ovr_gnt,
    input  logic             i_req0,
    input  logic             i_req1,
    input  logic             i_ovr_en,
    input  logic [WIDTH-1:0] i_data0,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_ovr_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    assign o_data  = (i_data0    & {WIDTH{i_gnt0}})
                   | (i_data1    & {WIDTH{i_gnt1}})
                   | (i_ovr_data & {WIDTH{i_ovr_gnt}});

    assign o_valid = (i_gnt0 & i_req0) | (i_gnt1 & i_req1) | (i_ovr_gnt & i_ovr_en);

endmodule

// File: rtl/ao_bus_arbiter.sv
// Round-robin, burst-aware arbiter for two requesters plus a priority
// override source, feeding one WIDTH-bit AND-OR merge path.
//   clk, rst              : clock, asynchronous active-high reset
//   req0/req1, data0/data1, last0/last1 : requester beats
//   gnt0/gnt1             : registered requester grants
//   ovr_en/ovr_data       : override request and word
//   ovr_gnt               : registered override grant
//   out_valid/out_data    : merged beat (combinational from grants + inputs)
//   out_ready             : downstream accepts the beat
module ao_bus_arbiter
    import ao_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             last0,
    input  logic             last1,
    output logic             gnt0,
    output logic             gnt1,
    input  logic             ovr_en,
    input  logic [WIDTH-1:0] ovr_data,
    output logic             ovr_gnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t    r_state;
    logic          r_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_ovr_gnt;

    arb_state_t    w_next;
    logic          w_next_ptr;
    logic [CW-1:0] w_next_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_accept;
    logic          w_valid;
    logic [WIDTH-1:0] w_data;

    ao_merge #(.WIDTH(WIDTH)) u_merge (
        .i_gnt0     (r_gnt0),
        .i_gnt1     (r_gnt1),
        .i_ovr_gnt  (r_ovr_gnt),
        .i_req0     (req0),
        .i_req1     (req1),
        .i_ovr_en   (ovr_en),
        .i_data0    (data0),
        .i_data1    (data1),
        .i_ovr_data (ovr_data),
        .o_valid    (w_valid),
        .o_data     (w_data)
    );

    assign w_accept  = w_valid & out_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_next     = r_state;
        w_next_ptr = r_ptr;
        w_next_cnt = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (ovr_en)             w_next = OVR;
                else if (req0 && req1)  w_next = r_ptr ? OWN1 : OWN0;
                else if (req0)          w_next = OWN0;
                else if (req1)          w_next = OWN1;
            end
            OWN0: begin
                if (w_accept) begin
                    w_next_cnt = w_cnt_inc;
                    // Release on last beat or burst cap; a coincidence is one release.
                    if (last0 || w_cnt_inc == CW'(MAX_BURST)) begin
                        w_next_cnt = '0;
                        w_next_ptr = 1'b1;
                        if (ovr_en)    w_next = OVR;
                        else if (req1) w_next = OWN1;
                        else           w_next = IDLE;
                    end
                end
            end
            OWN1: begin
                if (w_accept) begin
                    w_next_cnt = w_cnt_inc;
                    if (last1 || w_cnt_inc == CW'(MAX_BURST)) begin
                        w_next_cnt = '0;
                        w_next_ptr = 1'b0;
                        if (ovr_en)    w_next = OVR;
                        else if (req0) w_next = OWN0;
                        else           w_next = IDLE;
                    end
                end
            end
            OVR: begin
                if (!ovr_en) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Grants are registered alongside the state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= STATE_RST;
            r_ptr     <= PTR_RST;
            r_cnt     <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_ovr_gnt <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ptr     <= w_next_ptr;
            r_cnt     <= w_next_cnt;
            r_gnt0    <= (w_next == OWN0);
            r_gnt1    <= (w_next == OWN1);
            r_ovr_gnt <= (w_next == OVR);
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign ovr_gnt   = r_ovr_gnt;
    assign out_valid = w_valid;
    assign out_data  = w_data;

endmodule

// File: tb/tb_ao_bus_arbiter.sv
module tb_ao_bus_arbiter;

    localparam int W  = 8;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, last0, last1, ovr_en, out_ready;
    logic [W-1:0] data0, data1, ovr_data;
    logic         gnt0, gnt1, ovr_gnt, out_valid;
    logic [W-1:0] out_data;

    always #5 clk = ~clk;

    ao_bus_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .last0(last0), .last1(last1),
        .gnt0(gnt0), .gnt1(gnt1),
        .ovr_en(ovr_en), .ovr_data(ovr_data), .ovr_gnt(ovr_gnt),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
        logic         g0;
        logic         g1;
        logic         go;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: who holds the bus (-1 nobody, 0/1 requester, 2 override),
    // whose turn it is on a tie, and how many beats the holder has delivered.
    int holder = -1;
    int turn   = 0;
    int beats  = 0;

    task automatic step(input bit do_rst, input int mode);
        bit           r[2];
        bit           l[2];
        logic [W-1:0] d[2];
        exp_t         e;
        @(negedge clk);
        cyc++;
        rst = do_rst;
        d[0] = W'($urandom);
        d[1] = W'($urandom);
        case (mode)
            0: begin  // both requesters busy, short bursts
                r[0] = 1; r[1] = 1;
                l[0] = ($urandom_range(1) == 0); l[1] = ($urandom_range(1) == 0);
                out_ready = 1;
                ovr_en = 0;
            end
            1: begin  // long bursts without last, stalls and request gaps
                r[0] = ($urandom_range(5) != 0); r[1] = ($urandom_range(3) == 0);
                l[0] = 0; l[1] = 0;
                out_ready = ($urandom_range(3) != 0);
                ovr_en = 0;
            end
            2: begin  // override comes and goes in runs
                r[0] = ($urandom_range(3) != 0); r[1] = ($urandom_range(1) == 0);
                l[0] = ($urandom_range(2) == 0); l[1] = ($urandom_range(2) == 0);
                out_ready = ($urandom_range(4) != 0);
                if ($urandom_range(4) == 0) ovr_en = ~ovr_en;
            end
            default: begin
                r[0] = $urandom_range(1); r[1] = $urandom_range(1);
                l[0] = $urandom_range(1); l[1] = $urandom_range(1);
                out_ready = $urandom_range(1);
                ovr_en = $urandom_range(1);
            end
        endcase
        req0 = r[0]; req1 = r[1]; last0 = l[0]; last1 = l[1];
        data0 = d[0]; data1 = d[1];
        ovr_data = ($urandom_range(1) == 0) ? 8'hFF : W'($urandom);

        e = '0;
        if (do_rst) begin
            holder = -1; turn = 0; beats = 0;
            q.push_back(e);
            return;
        end
        if (holder == 2) begin
            e.go = 1; e.v = ovr_en; e.d = ovr_data;
        end else if (holder >= 0) begin
            e.g0 = (holder == 0); e.g1 = (holder == 1);
            e.v = r[holder]; e.d = d[holder];
        end
        q.push_back(e);

        // Advance the model to what the bus looks like after this edge.
        if (holder == -1) begin
            if (ovr_en)              holder = 2;
            else if (r[0] && r[1])   holder = turn;
            else if (r[0])           holder = 0;
            else if (r[1])           holder = 1;
        end else if (holder == 2) begin
            if (!ovr_en) holder = -1;
        end else if (e.v && out_ready) begin
            beats++;
            if (l[holder] || beats == MB) begin
                int other;
                other  = 1 - holder;
                beats  = 0;
                turn   = other;
                if (ovr_en)        holder = 2;
                else if (r[other]) holder = other;
                else               holder = -1;
            end
        end
    endtask

    // Monitor: checks every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_vec++;
                if ({out_valid, out_data, gnt0, gnt1, ovr_gnt} !== e) begin
                    n_bad++;
                    $display("FAIL beat@%0d: got v=%b d=%h g0=%b g1=%b go=%b, need v=%b d=%h g0=%b g1=%b go=%b",
                             n_vec, out_valid, out_data, gnt0, gnt1, ovr_gnt,
                             e.v, e.d, e.g0, e.g1, e.go);
                end
            end
        end
    end

    initial begin
        rst = 1; req0 = 0; req1 = 0; last0 = 0; last1 = 0;
        data0 = '0; data1 = '0; ovr_en = 0; ovr_data = '0; out_ready = 0;
        repeat (2) step(1, 3);
        repeat (60)  step(0, 0);
        repeat (120) step(0, 1);
        // Reset dropped into a live burst, then traffic restarts.
        repeat (2)   step(1, 1);
        repeat (150) step(0, 2);
        repeat (4)   step(0, 1);
        step(1, 0);
        repeat (400) step(0, 3);
        repeat (100) step(0, 1);
        @(negedge clk);
        #5;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries, need 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
